// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide controller with architectural HI/LO for the E stage.
// Optional macro MDU_DIV0_HOLD_EN: divide by zero keeps HI/LO instead of committing {A, all-ones}.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_E,
   input  logic [3:0]  op_E,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] mf_data
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;

   logic             is_arith;
   logic             is_div;
   logic             div_ovf;
   logic             b_zero;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic [31:0]        quo_u;
   logic [31:0]        rem_u;

   assign is_arith = (op_E == OP_MULT) || (op_E == OP_MULTU) ||
                     (op_E == OP_DIV)  || (op_E == OP_DIVU);
   assign is_div   = (op_E == OP_DIV) || (op_E == OP_DIVU);
   assign busy     = (state == S_BUSY);
   assign start    = en_E & is_arith & ~busy;
   assign mf_data  = (op_E == OP_MFHI) ? HI : LO;

   assign a_ext  = $signed({{32{A_E[31]}}, A_E});
   assign b_ext  = $signed({{32{B_E[31]}}, B_E});
   assign prod_s = a_ext * b_ext;
   assign prod_u = {32'd0, A_E} * {32'd0, B_E};

   assign a_s     = $signed(A_E);
   assign b_s     = $signed(B_E);
   assign b_zero  = (B_E == 32'd0);
   assign div_ovf = (A_E == 32'h8000_0000) && (B_E == 32'hFFFF_FFFF);
   assign quo_s   = a_s / b_s;
   assign rem_s   = a_s % b_s;
   assign quo_u   = A_E / B_E;
   assign rem_u   = A_E % B_E;

   // The full result is formed from the operands present at the start edge;
   // the busy counter only models the architectural latency.
   always_comb begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
      case (op_E)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (b_zero) begin
`ifdef MDU_DIV0_HOLD_EN
               res_hi = HI;
               res_lo = LO;
`else
               res_hi = A_E;
               res_lo = 32'hFFFF_FFFF;
`endif
            end else if (op_E == OP_DIVU) begin
               res_hi = rem_u;
               res_lo = quo_u;
            end else if (div_ovf) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = rem_s;
               res_lo = quo_s;
            end
         end
         default: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
      endcase
   end

   // HI/LO change only on a commit or an idle-state move-to; all md ops are dropped while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pend_hi <= res_hi;
                  pend_lo <= res_lo;
                  cnt     <= is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                  state   <= S_BUSY;
               end else if (en_E && (op_E == OP_MTHI)) begin
                  HI <= A_E;
               end else if (en_E && (op_E == OP_MTLO)) begin
                  LO <= A_E;
               end
            end
            S_BUSY: begin
               if (cnt == '0) begin
                  HI    <= pend_hi;
                  LO    <= pend_lo;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
